// File: rtl/dma_if_mux_rd_credit.sv
// rtl/dma_if_mux_rd_credit.sv - read-descriptor mux with per-port outstanding credit limit
// Arbitrates client descriptors onto one registered output and routes status back by tag MSBs.
module dma_if_mux_rd_credit #(
  parameter int PORTS                 = 4,
  parameter int S_RAM_SEL_WIDTH       = 2,
  parameter int M_RAM_SEL_WIDTH       = S_RAM_SEL_WIDTH + $clog2(PORTS),
  parameter int RAM_ADDR_WIDTH        = 16,
  parameter int DMA_ADDR_WIDTH        = 64,
  parameter int LEN_WIDTH             = 16,
  parameter int S_TAG_WIDTH           = 8,
  parameter int M_TAG_WIDTH           = S_TAG_WIDTH + $clog2(PORTS),
  parameter int MAX_OUTSTANDING       = 16,
  parameter int ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  output logic [DMA_ADDR_WIDTH-1:0]                    m_axis_read_desc_dma_addr,
  output logic [M_RAM_SEL_WIDTH-1:0]                   m_axis_read_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0]                    m_axis_read_desc_ram_addr,
  output logic [LEN_WIDTH-1:0]                         m_axis_read_desc_len,
  output logic [M_TAG_WIDTH-1:0]                       m_axis_read_desc_tag,
  output logic                                         m_axis_read_desc_valid,
  input  logic                                         m_axis_read_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]                       s_axis_read_desc_status_tag,
  input  logic [3:0]                                   s_axis_read_desc_status_error,
  input  logic                                         s_axis_read_desc_status_valid,
  input  logic [PORTS*DMA_ADDR_WIDTH-1:0]              s_axis_read_desc_dma_addr,
  input  logic [PORTS*S_RAM_SEL_WIDTH-1:0]             s_axis_read_desc_ram_sel,
  input  logic [PORTS*RAM_ADDR_WIDTH-1:0]              s_axis_read_desc_ram_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]                   s_axis_read_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]                 s_axis_read_desc_tag,
  input  logic [PORTS-1:0]                             s_axis_read_desc_valid,
  output logic [PORTS-1:0]                             s_axis_read_desc_ready,
  output logic [PORTS*S_TAG_WIDTH-1:0]                 m_axis_read_desc_status_tag,
  output logic [PORTS*4-1:0]                           m_axis_read_desc_status_error,
  output logic [PORTS-1:0]                             m_axis_read_desc_status_valid,
  input  logic [PORTS-1:0]                             port_enable,
  output logic [PORTS*$clog2(MAX_OUTSTANDING+1)-1:0]   port_outstanding,
  output logic [PORTS-1:0]                             port_busy,
  output logic                                         stat_unexpected_status
);

  localparam int CL = $clog2(PORTS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CL-1:0] RST_PTR = (ARB_LSB_HIGH_PRIORITY != 0) ? CL'(PORTS - 1) : CL'(1);

  logic [PORTS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [PORTS-1:0]                  busy_q;
  logic [PORTS-1:0]                  eligible, grant, route_hit;
  logic                              grant_vld, load, unexpected;
  logic [CL-1:0]                     grant_idx, last_q, st_port;
  logic [CL:0]                       idx_w;
  logic [DMA_ADDR_WIDTH-1:0]         sel_dma_addr;
  logic [S_RAM_SEL_WIDTH-1:0]        sel_ram_sel;
  logic [RAM_ADDR_WIDTH-1:0]         sel_ram_addr;
  logic [LEN_WIDTH-1:0]              sel_len;
  logic [S_TAG_WIDTH-1:0]            sel_tag;
  logic                              m_valid_q;
  logic [DMA_ADDR_WIDTH-1:0]         m_dma_addr_q;
  logic [M_RAM_SEL_WIDTH-1:0]        m_ram_sel_q;
  logic [RAM_ADDR_WIDTH-1:0]         m_ram_addr_q;
  logic [LEN_WIDTH-1:0]              m_len_q;
  logic [M_TAG_WIDTH-1:0]            m_tag_q;
  logic [PORTS-1:0][S_TAG_WIDTH-1:0] st_tag_q;
  logic [PORTS-1:0][3:0]             st_err_q;
  logic [PORTS-1:0]                  st_valid_q;
  logic                              unexpected_q;

  assign load = !m_valid_q || m_axis_read_desc_ready;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      eligible[i] = s_axis_read_desc_valid[i] && port_enable[i] && (cnt_q[i] < MAX_CNT);
    end
  end

  // Round robin walks PORTS candidates starting next to the last grant; the last
  // candidate examined is the last-granted port itself.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx_w     = '0;
    if (load) begin
      if (ARB_TYPE_ROUND_ROBIN != 0) begin
        for (int k = 1; k <= PORTS; k++) begin
          if (ARB_LSB_HIGH_PRIORITY != 0) idx_w = {1'b0, last_q} + (CL+1)'(k);
          else                            idx_w = {1'b0, last_q} + (CL+1)'(PORTS - k);
          if (idx_w >= (CL+1)'(PORTS)) idx_w = idx_w - (CL+1)'(PORTS);
          if (!grant_vld && eligible[idx_w[CL-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = idx_w[CL-1:0];
          end
        end
      end else if (ARB_LSB_HIGH_PRIORITY != 0) begin
        for (int i = PORTS - 1; i >= 0; i--) begin
          if (eligible[i]) begin
            grant_vld = 1'b1;
            grant_idx = CL'(i);
          end
        end
      end else begin
        for (int i = 0; i < PORTS; i++) begin
          if (eligible[i]) begin
            grant_vld = 1'b1;
            grant_idx = CL'(i);
          end
        end
      end
    end
    grant = grant_vld ? (PORTS'(1) << grant_idx) : '0;
  end

  assign s_axis_read_desc_ready = grant;

  always_comb begin
    sel_dma_addr = '0;
    sel_ram_sel  = '0;
    sel_ram_addr = '0;
    sel_len      = '0;
    sel_tag      = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_idx == CL'(i)) begin
        sel_dma_addr = s_axis_read_desc_dma_addr[i*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
        sel_ram_sel  = s_axis_read_desc_ram_sel[i*S_RAM_SEL_WIDTH +: S_RAM_SEL_WIDTH];
        sel_ram_addr = s_axis_read_desc_ram_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
        sel_len      = s_axis_read_desc_len[i*LEN_WIDTH +: LEN_WIDTH];
        sel_tag      = s_axis_read_desc_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH];
      end
    end
  end

  // Index compare against i < PORTS rejects out-of-range tags without indexing past the array.
  assign st_port = s_axis_read_desc_status_tag[M_TAG_WIDTH-1 -: CL];

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      route_hit[i] = s_axis_read_desc_status_valid && (st_port == CL'(i)) && (cnt_q[i] != '0);
      case ({grant[i], route_hit[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    unexpected = s_axis_read_desc_status_valid && !(|route_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q    <= 1'b0;
      m_dma_addr_q <= '0;
      m_ram_sel_q  <= '0;
      m_ram_addr_q <= '0;
      m_len_q      <= '0;
      m_tag_q      <= '0;
      last_q       <= RST_PTR;
      cnt_q        <= '0;
      busy_q       <= '0;
      st_tag_q     <= '0;
      st_err_q     <= '0;
      st_valid_q   <= '0;
      unexpected_q <= 1'b0;
    end else begin
      m_valid_q <= grant_vld || (m_valid_q && !m_axis_read_desc_ready);
      if (grant_vld) begin
        m_dma_addr_q <= sel_dma_addr;
        m_ram_sel_q  <= {grant_idx, sel_ram_sel};
        m_ram_addr_q <= sel_ram_addr;
        m_len_q      <= sel_len;
        m_tag_q      <= {grant_idx, sel_tag};
        if (ARB_TYPE_ROUND_ROBIN != 0) last_q <= grant_idx;
      end
      cnt_q <= cnt_d;
      for (int i = 0; i < PORTS; i++) begin
        busy_q[i] <= (cnt_d[i] != '0);
        if (route_hit[i]) begin
          st_tag_q[i] <= s_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
          st_err_q[i] <= s_axis_read_desc_status_error;
        end
      end
      st_valid_q   <= route_hit;
      unexpected_q <= unexpected;
    end
  end

  assign m_axis_read_desc_valid        = m_valid_q;
  assign m_axis_read_desc_dma_addr     = m_dma_addr_q;
  assign m_axis_read_desc_ram_sel      = m_ram_sel_q;
  assign m_axis_read_desc_ram_addr     = m_ram_addr_q;
  assign m_axis_read_desc_len          = m_len_q;
  assign m_axis_read_desc_tag          = m_tag_q;
  assign m_axis_read_desc_status_tag   = st_tag_q;
  assign m_axis_read_desc_status_error = st_err_q;
  assign m_axis_read_desc_status_valid = st_valid_q;
  assign port_outstanding              = cnt_q;
  assign port_busy                     = busy_q;
  assign stat_unexpected_status        = unexpected_q;

endmodule

// File: tb/tb_dma_if_mux_rd_credit.sv
// tb/tb_dma_if_mux_rd_credit.sv - directed bench for dma_if_mux_rd_credit
// Table of single-cycle arbitration vectors plus hand sequences for credit, status and reset.
module tb_dma_if_mux_rd_credit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0]  m_dma;
  logic [3:0]   m_rsel;
  logic [15:0]  m_raddr, m_len;
  logic [9:0]   m_tag;
  logic         m_valid, m_ready;
  logic [9:0]   st_tag;
  logic [3:0]   st_err;
  logic         st_valid;
  logic [255:0] s_dma;
  logic [7:0]   s_rsel;
  logic [63:0]  s_raddr, s_len;
  logic [31:0]  s_tag;
  logic [3:0]   s_valid, s_ready, ms_valid, en, busy;
  logic [31:0]  ms_tag;
  logic [15:0]  ms_err;
  logic [19:0]  outst;
  logic         unexp;

  dma_if_mux_rd_credit dut (
    .clk(clk), .rst_n(rst_n),
    .m_axis_read_desc_dma_addr(m_dma), .m_axis_read_desc_ram_sel(m_rsel),
    .m_axis_read_desc_ram_addr(m_raddr), .m_axis_read_desc_len(m_len),
    .m_axis_read_desc_tag(m_tag), .m_axis_read_desc_valid(m_valid),
    .m_axis_read_desc_ready(m_ready),
    .s_axis_read_desc_status_tag(st_tag), .s_axis_read_desc_status_error(st_err),
    .s_axis_read_desc_status_valid(st_valid),
    .s_axis_read_desc_dma_addr(s_dma), .s_axis_read_desc_ram_sel(s_rsel),
    .s_axis_read_desc_ram_addr(s_raddr), .s_axis_read_desc_len(s_len),
    .s_axis_read_desc_tag(s_tag), .s_axis_read_desc_valid(s_valid),
    .s_axis_read_desc_ready(s_ready),
    .m_axis_read_desc_status_tag(ms_tag), .m_axis_read_desc_status_error(ms_err),
    .m_axis_read_desc_status_valid(ms_valid),
    .port_enable(en), .port_outstanding(outst), .port_busy(busy),
    .stat_unexpected_status(unexp)
  );

  logic [63:0]  m3_dma;
  logic [3:0]   m3_rsel;
  logic [15:0]  m3_raddr, m3_len;
  logic [9:0]   m3_tag, st3_tag;
  logic         m3_valid, st3_valid, unexp3;
  logic [191:0] s3_dma;
  logic [5:0]   s3_rsel;
  logic [47:0]  s3_raddr, s3_len;
  logic [23:0]  s3_tag, ms3_tag;
  logic [2:0]   s3_valid, s3_ready, ms3_valid, en3, busy3;
  logic [11:0]  ms3_err;
  logic [14:0]  outst3;

  dma_if_mux_rd_credit #(.PORTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .m_axis_read_desc_dma_addr(m3_dma), .m_axis_read_desc_ram_sel(m3_rsel),
    .m_axis_read_desc_ram_addr(m3_raddr), .m_axis_read_desc_len(m3_len),
    .m_axis_read_desc_tag(m3_tag), .m_axis_read_desc_valid(m3_valid),
    .m_axis_read_desc_ready(1'b1),
    .s_axis_read_desc_status_tag(st3_tag), .s_axis_read_desc_status_error(4'h0),
    .s_axis_read_desc_status_valid(st3_valid),
    .s_axis_read_desc_dma_addr(s3_dma), .s_axis_read_desc_ram_sel(s3_rsel),
    .s_axis_read_desc_ram_addr(s3_raddr), .s_axis_read_desc_len(s3_len),
    .s_axis_read_desc_tag(s3_tag), .s_axis_read_desc_valid(s3_valid),
    .s_axis_read_desc_ready(s3_ready),
    .m_axis_read_desc_status_tag(ms3_tag), .m_axis_read_desc_status_error(ms3_err),
    .m_axis_read_desc_status_valid(ms3_valid),
    .port_enable(en3), .port_outstanding(outst3), .port_busy(busy3),
    .stat_unexpected_status(unexp3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] sv;
    logic [3:0] en;
    logic       mr;
    logic [3:0] exp_rdy;
    logic       exp_v;
    int         exp_p;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; m_ready = 1'b0; st_tag = '0; st_err = '0; st_valid = 1'b0;
    s_valid = '0; en = 4'hF;
    for (int i = 0; i < 4; i++) begin
      s_dma[i*64 +: 64]   = 64'h1000 * (i + 1);
      s_rsel[i*2 +: 2]    = 2'(i);
      s_raddr[i*16 +: 16] = 16'h0100 + 16'(i);
      s_len[i*16 +: 16]   = 16'h0020 + 16'(i);
      s_tag[i*8 +: 8]     = 8'h10 + 8'(i);
    end
    s3_dma = '0; s3_rsel = '0; s3_raddr = '0; s3_len = '0; s3_tag = '0;
    s3_valid = '0; en3 = 3'b111; st3_tag = '0; st3_valid = 1'b0;

    //           sv       en     mr    rdy      v     p
    tbl.push_back('{4'b0101, 4'hF, 1'b1, 4'b0001, 1'b1, 0});
    tbl.push_back('{4'b0101, 4'hF, 1'b1, 4'b0100, 1'b1, 2});
    tbl.push_back('{4'b0101, 4'hF, 1'b1, 4'b0001, 1'b1, 0});
    tbl.push_back('{4'b0101, 4'hF, 1'b1, 4'b0100, 1'b1, 2});
    tbl.push_back('{4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2});
    tbl.push_back('{4'b0001, 4'hE, 1'b1, 4'b0000, 1'b0, 2});
    tbl.push_back('{4'b1111, 4'hF, 1'b1, 4'b1000, 1'b1, 3});
    for (int r = 0; r < 5; r++) tbl.push_back('{4'b1111, 4'hF, 1'b0, 4'b0000, 1'b1, 3});
    tbl.push_back('{4'b1111, 4'hF, 1'b1, 4'b0001, 1'b1, 0});
    tbl.push_back('{4'b1111, 4'hF, 1'b1, 4'b0010, 1'b1, 1});
    tbl.push_back('{4'b0000, 4'hF, 1'b0, 4'b0000, 1'b1, 1});
    tbl.push_back('{4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 1});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_tag", m_tag, 0);
    chk("rst_m_dma", m_dma, 0);
    chk("rst_status_valid", ms_valid, 0);
    chk("rst_outstanding", outst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_unexpected", unexp, 0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[r]) begin
      int p;
      p = tbl[r].exp_p;
      s_valid = tbl[r].sv; en = tbl[r].en; m_ready = tbl[r].mr;
      #1;
      chk($sformatf("row%0d_s_ready", r), s_ready, tbl[r].exp_rdy);
      tick();
      chk($sformatf("row%0d_m_valid", r), m_valid, tbl[r].exp_v);
      if (tbl[r].exp_v) begin
        chk($sformatf("row%0d_m_tag", r), m_tag, {2'(p), 8'h10 + 8'(p)});
        chk($sformatf("row%0d_m_ram_sel", r), m_rsel, {2'(p), 2'(p)});
        chk($sformatf("row%0d_m_dma", r), m_dma, 64'h1000 * (p + 1));
        chk($sformatf("row%0d_m_ram_addr", r), m_raddr, 16'h0100 + 16'(p));
        chk($sformatf("row%0d_m_len", r), m_len, 16'h0020 + 16'(p));
      end
    end
    chk("tbl_cnt0", outst[4:0], 3);
    chk("tbl_cnt1", outst[9:5], 1);
    chk("tbl_cnt2", outst[14:10], 2);
    chk("tbl_cnt3", outst[19:15], 1);
    chk("tbl_busy", busy, 4'hF);

    st_tag = 10'h2A5; st_err = 4'h3; st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
    chk("st2_valid", ms_valid, 4'b0100);
    chk("st2_tag", ms_tag[23:16], 8'hA5);
    chk("st2_err", ms_err[11:8], 4'h3);
    chk("st2_cnt", outst[14:10], 1);
    chk("st2_unexp", unexp, 0);
    tick();
    chk("st2_pulse_end", ms_valid, 0);

    st_tag = 10'h301; st_err = 4'h0; st_valid = 1'b1;
    tick();
    chk("st3_valid", ms_valid, 4'b1000);
    chk("st3_cnt", outst[19:15], 0);
    chk("st3_busy", busy[3], 0);
    st_tag = 10'h302; st3_tag = 10'h3A5; st3_valid = 1'b1;
    tick();
    st_valid = 1'b0; st3_valid = 1'b0;
    chk("unexp_zero_cnt", unexp, 1);
    chk("unexp_no_valid", ms_valid, 0);
    chk("unexp_cnt3", outst[19:15], 0);
    chk("unexp_cnt0", outst[4:0], 3);
    chk("unexp_range_p3", unexp3, 1);
    chk("unexp_range_valid_p3", ms3_valid, 0);
    chk("unexp_range_cnt_p3", outst3, 0);
    tick();
    chk("unexp_pulse_end", unexp, 0);

    s_valid = 4'b0010; m_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk($sformatf("credit_rdy%0d", k), s_ready[1], 1);
      tick();
    end
    chk("credit_full_cnt", outst[9:5], 16);
    #1;
    chk("credit_17th_blocked", s_ready, 0);
    st_tag = 10'h107; st_valid = 1'b1;
    #1;
    chk("credit_blocked_with_status", s_ready, 0);
    tick();
    st_valid = 1'b0;
    chk("credit_release_cnt", outst[9:5], 15);
    chk("credit_release_status", ms_valid, 4'b0010);
    #1;
    chk("credit_release_rdy", s_ready, 4'b0010);
    tick();
    chk("credit_refill_cnt", outst[9:5], 16);
    chk("credit_refill_tag", m_tag, 10'h111);

    s_valid = 4'b0001; st_tag = 10'h055; st_valid = 1'b1;
    #1;
    chk("same_cycle_rdy", s_ready, 4'b0001);
    tick();
    st_valid = 1'b0; s_valid = 4'b0000;
    chk("same_cycle_cnt0", outst[4:0], 3);
    chk("same_cycle_status", ms_valid, 4'b0001);
    chk("same_cycle_tag", ms_tag[7:0], 8'h55);
    chk("same_cycle_m_tag", m_tag, 10'h010);

    s_valid = 4'b1111; m_ready = 1'b0;
    tick();
    chk("prereset_valid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_tag", m_tag, 0);
    chk("midrst_cnt", outst, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_status", ms_valid, 0);
    tick();
    rst_n = 1'b1; m_ready = 1'b1;
    #1;
    chk("postrst_rdy", s_ready, 4'b0001);
    tick();
    chk("postrst_tag", m_tag, 10'h010);
    chk("postrst_cnt0", outst[4:0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
